// File: rtl/ncc_pkg.sv
// Shared types for the ncc window feeder path:
// pixel/window bundles and the feeder state encoding.
package ncc_pkg;

    localparam int WIN_DIM = 16;

    typedef bit [7:0] pixel_t;
    typedef pixel_t [WIN_DIM-1:0][WIN_DIM-1:0] window_t;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        PRESENT,
        ADVANCE,
        DONE
    } feeder_state_t;

endpackage

// File: rtl/ncc_band_buffer.sv
// 16-row band store with one byte write port and a
// combinational 16x16 read window at a base column.
module ncc_band_buffer
    import ncc_pkg::*;
#(
    parameter int BAND_W = 40
) (
    input  logic                                   clk,
    input  logic                                   we_i,
    input  logic [3:0]                             row_i,
    input  logic [$clog2(BAND_W)-1:0]              col_i,
    input  logic [7:0]                             data_i,
    input  logic [$clog2(BAND_W)-1:0]              base_i,
    output logic [WIN_DIM-1:0][WIN_DIM-1:0][7:0]   win_o
);

    localparam int CW = $clog2(BAND_W);

    logic [7:0] mem_q [WIN_DIM][BAND_W];

    // Contents are only meaningful after a full fill, so no reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[row_i][col_i] <= data_i;
        end
    end

    always_comb begin
        win_o = '0;
        for (int r = 0; r < WIN_DIM; r++) begin
            for (int c = 0; c < WIN_DIM; c++) begin
                win_o[r][c] = mem_q[r][base_i + CW'(c)];
            end
        end
    end

endmodule

// File: rtl/ncc_window_feeder.sv
// Fills a 16-row band, then presents each 16x16 window to ncc
// with a forced one-cycle gap between windows.
module ncc_window_feeder
    import ncc_pkg::*;
#(
    parameter int BAND_W = 40,
    parameter int WIN    = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   band_start,
    input  logic                                   pix_valid,
    input  logic [7:0]                             pix_data,
    output logic                                   pix_ready,
    output logic [WIN_DIM-1:0][WIN_DIM-1:0][7:0]   window_data_out,
    output logic                                   window_data_ready,
    input  logic                                   done_with_window_data,
    output logic [$clog2(BAND_W)-1:0]              win_col,
    output logic                                   band_done
);

    localparam int CW = $clog2(BAND_W);
    localparam logic [CW-1:0] LAST_COL = CW'(BAND_W - 1);
    localparam logic [CW-1:0] LAST_WIN = CW'(BAND_W - WIN_DIM);

    if (WIN != WIN_DIM) begin : g_win_chk
        $error("ncc_window_feeder: WIN must be 16");
    end

    if (BAND_W < WIN_DIM || BAND_W > 256) begin : g_bw_chk
        $error("ncc_window_feeder: BAND_W must be 16..256");
    end

    feeder_state_t   state_q, state_d;
    logic [3:0]      frow_q, frow_d;
    logic [CW-1:0]   fcol_q, fcol_d;
    logic [CW-1:0]   wcol_q, wcol_d;
    logic            we;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            frow_q  <= '0;
            fcol_q  <= '0;
            wcol_q  <= '0;
        end else begin
            state_q <= state_d;
            frow_q  <= frow_d;
            fcol_q  <= fcol_d;
            wcol_q  <= wcol_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        frow_d            = frow_q;
        fcol_d            = fcol_q;
        wcol_d            = wcol_q;
        pix_ready         = 1'b0;
        window_data_ready = 1'b0;
        band_done         = 1'b0;
        we                = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (band_start) begin
                    state_d = FILL;
                    frow_d  = '0;
                    fcol_d  = '0;
                end
            end
            FILL: begin
                pix_ready = 1'b1;
                if (pix_valid) begin
                    we = 1'b1;
                    if (fcol_q == LAST_COL) begin
                        fcol_d = '0;
                        frow_d = frow_q + 4'd1;
                        if (frow_q == 4'd15) begin
                            state_d = PRESENT;
                            wcol_d  = '0;
                        end
                    end else begin
                        fcol_d = fcol_q + CW'(1);
                    end
                end
            end
            PRESENT: begin
                window_data_ready = 1'b1;
                if (done_with_window_data) begin
                    state_d = ADVANCE;
                end
            end
            // The gap lets ncc fall back to WIN_WAIT before ready rises again.
            ADVANCE: begin
                if (wcol_q == LAST_WIN) begin
                    state_d = DONE;
                end else begin
                    wcol_d  = wcol_q + CW'(1);
                    state_d = PRESENT;
                end
            end
            DONE: begin
                band_done = 1'b1;
                wcol_d    = '0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign win_col = wcol_q;

    ncc_band_buffer #(
        .BAND_W (BAND_W)
    ) u_buf (
        .clk    (clk),
        .we_i   (we),
        .row_i  (frow_q),
        .col_i  (fcol_q),
        .data_i (pix_data),
        .base_i (wcol_q),
        .win_o  (window_data_out)
    );

endmodule
